// File: rtl/crypto1_pkg.sv
// Shared types and widths for the Crypto1 key-recovery subkey arbiter.
package crypto1_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SCAN  = 3'd2,
    READ  = 3'd3,
    HOLD  = 3'd4
  } arb_state_t;

  localparam int SUBKEY_W    = 24;
  localparam int BITSTREAM_W = 5;

endpackage

// File: rtl/subkey_arbiter_rr_select.sv
// Round-robin find-first: returns the first requesting lane at or above ptr,
// wrapping past N-1 back to lane 0.
module rr_select #(
  parameter int N = 16,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] ptr,
  output logic          found,
  output logic [LW-1:0] idx
);

  logic [LW-1:0] cand;

  // Walk offsets from farthest to nearest so the lane closest to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = LW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/subkey_arbiter.sv
// Sequencer and round-robin arbiter draining N subkey-generator lane FIFOs
// into one valid/ready stream, with run start, abort and completion tracking.
module subkey_arbiter
  import crypto1_pkg::*;
#(
  parameter int N = 16,
  parameter int CNT_W = 32,
  localparam int LW = $clog2(N)
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   START,
  input  logic                   ABORT,
  input  logic [BITSTREAM_W-1:0] BITSTREAM,
  output logic [BITSTREAM_W-1:0] LANE_BITSTREAM,
  output logic                   LANE_RESETn,
  input  logic [N-1:0]           LANE_DONE,
  input  logic [N-1:0]           LANE_EMPTY,
  input  logic [SUBKEY_W*N-1:0]  LANE_RDDATA,
  output logic [N-1:0]           LANE_RDEN,
  output logic                   OUT_VALID,
  input  logic                   OUT_READY,
  output logic [SUBKEY_W-1:0]    OUT_DATA,
  output logic [LW-1:0]          OUT_LANE,
  output logic                   BUSY,
  output logic                   DONE,
  output logic [CNT_W-1:0]       SUBKEY_CNT
);

  arb_state_t    state, next;
  logic [LW-1:0] ptr;
  logic [LW-1:0] gnt;
  logic          clr_cnt;
  logic          found;
  logic [LW-1:0] sel;
  logic [N-1:0]  req;
  logic          abort_run;

  // Counter holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign req       = ~LANE_EMPTY;
  assign abort_run = ABORT && (state != IDLE);

  rr_select #(.N(N), .LW(LW)) u_sel (
    .req  (req),
    .ptr  (ptr),
    .found(found),
    .idx  (sel)
  );

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= next;
  end

  // Next-state logic; an abort overrides every non-idle transition.
  always_comb begin
    next = state;
    case (state)
      IDLE:  if (START && !ABORT) next = CLEAR;
      CLEAR: if (clr_cnt) next = SCAN;
      SCAN:  if (found) next = READ;
             else if (&LANE_DONE) next = IDLE;
      READ:  next = HOLD;
      HOLD:  if (OUT_VALID && OUT_READY) next = SCAN;
      default: next = IDLE;
    endcase
    if (abort_run) next = IDLE;
  end

  // Lane-facing strobes decoded from the current state.
  always_comb begin
    LANE_RDEN   = '0;
    BUSY        = (state != IDLE);
    LANE_RESETn = (state == SCAN) || (state == READ) || (state == HOLD);
    if (state == SCAN && found && !ABORT) LANE_RDEN[sel] = 1'b1;
  end

  // Run bookkeeping, grant capture and the output holding register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      LANE_BITSTREAM <= '0;
      DONE           <= 1'b0;
      SUBKEY_CNT     <= '0;
      ptr            <= '0;
      gnt            <= '0;
      clr_cnt        <= 1'b0;
      OUT_VALID      <= 1'b0;
      OUT_DATA       <= '0;
      OUT_LANE       <= '0;
    end else if (abort_run) begin
      OUT_VALID <= 1'b0;
    end else begin
      case (state)
        IDLE: if (START && !ABORT) begin
          LANE_BITSTREAM <= BITSTREAM;
          DONE           <= 1'b0;
          SUBKEY_CNT     <= '0;
          ptr            <= '0;
          clr_cnt        <= 1'b0;
        end
        CLEAR: clr_cnt <= 1'b1;
        SCAN: begin
          if (found) gnt <= sel;
          else if (&LANE_DONE) DONE <= 1'b1;
        end
        READ: begin
          OUT_DATA  <= LANE_RDDATA[int'(gnt)*SUBKEY_W +: SUBKEY_W];
          OUT_LANE  <= gnt;
          OUT_VALID <= 1'b1;
        end
        HOLD: if (OUT_VALID && OUT_READY) begin
          OUT_VALID  <= 1'b0;
          SUBKEY_CNT <= sat_inc(SUBKEY_CNT);
          ptr        <= (gnt == LW'(N - 1)) ? '0 : gnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_subkey_arbiter.sv
// Self-checking bench for subkey_arbiter with N=4 lanes and modelled lane FIFOs.
module tb_subkey_arbiter;

  localparam int N = 4;
  localparam int CNT_W = 32;
  localparam int LW = 2;

  logic              CLK = 1'b0;
  logic              RESET, START, ABORT, OUT_READY;
  logic [4:0]        BITSTREAM, LANE_BITSTREAM;
  logic              LANE_RESETn, OUT_VALID, BUSY, DONE;
  logic [N-1:0]      LANE_DONE, LANE_EMPTY, LANE_RDEN;
  logic [24*N-1:0]   LANE_RDDATA;
  logic [23:0]       OUT_DATA;
  logic [LW-1:0]     OUT_LANE;
  logic [CNT_W-1:0]  SUBKEY_CNT;

  subkey_arbiter #(.N(N), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .ABORT(ABORT),
    .BITSTREAM(BITSTREAM), .LANE_BITSTREAM(LANE_BITSTREAM),
    .LANE_RESETn(LANE_RESETn), .LANE_DONE(LANE_DONE), .LANE_EMPTY(LANE_EMPTY),
    .LANE_RDDATA(LANE_RDDATA), .LANE_RDEN(LANE_RDEN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_DATA(OUT_DATA),
    .OUT_LANE(OUT_LANE), .BUSY(BUSY), .DONE(DONE), .SUBKEY_CNT(SUBKEY_CNT)
  );

  always #5 CLK = ~CLK;

  // Lane FIFO model: one-cycle read latency, flushed while lanes are held in restart.
  logic [23:0] mem [N][256];
  logic [7:0]  wp [N];
  logic [7:0]  rp [N];
  logic [23:0] rdat [N];
  int          cyc = 0;

  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (!LANE_RESETn) rp[i] <= wp[i];
      else if (LANE_RDEN[i]) begin
        rdat[i] <= mem[i][rp[i]];
        rp[i]   <= rp[i] + 8'd1;
      end
    end
  end

  always_comb begin
    LANE_EMPTY  = '1;
    LANE_RDDATA = '0;
    for (int i = 0; i < N; i++) begin
      LANE_EMPTY[i]         = (wp[i] == rp[i]);
      LANE_RDDATA[24*i +: 24] = rdat[i];
    end
  end

  // Bench bookkeeping.
  int          checks = 0;
  int          errors = 0;
  logic [23:0] ld [N][64];
  int          ln [N];
  int          done_at [N];
  int          exp_lane[$];
  logic [23:0] exp_data[$];
  int          got_lane[$];
  logic [23:0] got_data[$];
  int          acc_cyc[$];

  typedef struct packed {
    logic [15:0] cnt;    // 4 bits per lane, lane 0 in the low nibble
    logic [15:0] order;  // 2 bits per expected output, first in the low bits
    logic [3:0]  n_out;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic push(input int l, input logic [23:0] d);
    mem[l][wp[l]] = d;
    wp[l] = wp[l] + 8'd1;
    ld[l][ln[l]] = d;
    ln[l]++;
  endtask

  task automatic accept();
    OUT_READY = 1'b1;
    tick();
    OUT_READY = 1'b0;
    #1;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 20; k++) begin
      if (OUT_VALID) break;
      tick();
      #1;
    end
    chk("wait_valid", OUT_VALID, 1);
  endtask

  // Start a run and confirm the two-cycle lane restart; returns in the first SCAN cycle.
  task automatic start_run(input logic [4:0] bs);
    for (int i = 0; i < N; i++) ln[i] = 0;
    BITSTREAM = bs;
    START = 1'b1;
    tick();
    START = 1'b0;
    #1;
    chk("clear1_resetn", LANE_RESETn, 0);
    chk("start_busy", BUSY, 1);
    chk("start_bitstream", LANE_BITSTREAM, bs);
    chk("start_done_clr", DONE, 0);
    chk("start_cnt_clr", SUBKEY_CNT, 0);
    tick(); #1;
    chk("clear2_resetn", LANE_RESETn, 0);
    tick(); #1;
    chk("scan_resetn", LANE_RESETn, 1);
  endtask

  // Reference ordering: repeatedly take the first lane with data at or after the pointer.
  task automatic build_model();
    int taken [N];
    int ptr;
    int left;
    exp_lane.delete();
    exp_data.delete();
    left = 0;
    for (int i = 0; i < N; i++) begin
      taken[i] = 0;
      left += ln[i];
    end
    ptr = 0;
    while (left > 0) begin
      for (int k = 0; k < N; k++) begin
        int l;
        l = (ptr + k) % N;
        if (taken[l] < ln[l]) begin
          exp_lane.push_back(l);
          exp_data.push_back(ld[l][taken[l]]);
          taken[l]++;
          left--;
          ptr = (l + 1) % N;
          break;
        end
      end
    end
  endtask

  task automatic drain(input int max_cyc, input bit rnd);
    bit fin = 0;
    bit pv = 0;
    bit pr = 0;
    logic [23:0] pd = '0;
    logic [LW-1:0] pl = '0;
    int bad_rd = 0;
    int bad_hold = 0;
    got_lane.delete();
    got_data.delete();
    acc_cyc.delete();
    for (int c = 0; c < max_cyc; c++) begin
      for (int i = 0; i < N; i++) if (c >= done_at[i]) LANE_DONE[i] = 1'b1;
      OUT_READY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (!BUSY && DONE) begin
        fin = 1;
        break;
      end
      if ((LANE_RDEN & (LANE_RDEN - 1'b1)) != 0 || (LANE_RDEN & LANE_EMPTY) != 0) bad_rd++;
      if (pv && !pr && (!OUT_VALID || OUT_DATA !== pd || OUT_LANE !== pl)) bad_hold++;
      if (OUT_VALID && OUT_READY) begin
        got_lane.push_back(int'(OUT_LANE));
        got_data.push_back(OUT_DATA);
        acc_cyc.push_back(cyc);
      end
      pv = OUT_VALID;
      pr = OUT_READY;
      pd = OUT_DATA;
      pl = OUT_LANE;
      tick();
    end
    OUT_READY = 1'b0;
    chk("drain_finished", fin, 1);
    chk("rden_legal", bad_rd, 0);
    chk("hold_stable", bad_hold, 0);
  endtask

  task automatic check_run(input string tag);
    chk({tag, "_count"}, got_lane.size(), exp_lane.size());
    for (int i = 0; i < got_lane.size() && i < exp_lane.size(); i++) begin
      chk({tag, "_lane"}, got_lane[i], exp_lane[i]);
      chk({tag, "_data"}, got_data[i], exp_data[i]);
    end
    chk({tag, "_subkey_cnt"}, SUBKEY_CNT, exp_lane.size());
    chk({tag, "_done"}, DONE, 1);
    chk({tag, "_busy"}, BUSY, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [23:0] d;
    logic [LW-1:0] l;

    tbl[0] = '{cnt: 16'h0303, order: 16'h0888, n_out: 4'd6};  // lanes 0,2 x3
    tbl[1] = '{cnt: 16'h1000, order: 16'h0003, n_out: 4'd1};  // lane 3 only
    tbl[2] = '{cnt: 16'h0021, order: 16'h0014, n_out: 4'd3};  // 0,1,1
    tbl[3] = '{cnt: 16'h1112, order: 16'h00E4, n_out: 4'd5};  // 0,1,2,3,0
    tbl[4] = '{cnt: 16'h0000, order: 16'h0000, n_out: 4'd0};  // nothing to drain
    tbl[5] = '{cnt: 16'h0020, order: 16'h0005, n_out: 4'd2};  // lane 1 holds DONE back

    RESET = 1'b1; START = 1'b0; ABORT = 1'b0; BITSTREAM = '0;
    LANE_DONE = '0; OUT_READY = 1'b0;
    for (int i = 0; i < N; i++) begin
      wp[i] = '0; ln[i] = 0; done_at[i] = 0;
    end
    repeat (3) tick();
    #1;
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_valid", OUT_VALID, 0);
    chk("rst_data", OUT_DATA, 0);
    chk("rst_lane", OUT_LANE, 0);
    chk("rst_resetn", LANE_RESETn, 0);
    chk("rst_rden", LANE_RDEN, 0);
    chk("rst_bitstream", LANE_BITSTREAM, 0);
    chk("rst_cnt", SUBKEY_CNT, 0);
    RESET = 1'b0;
    tick(); #1;
    chk("idle_busy", BUSY, 0);

    // Table-driven preload runs with downstream always ready.
    for (int t = 0; t < 6; t++) begin
      LANE_DONE = '0;
      for (int i = 0; i < N; i++) done_at[i] = 0;
      start_run(t == 0 ? 5'h15 : 5'(t + 1));
      for (int i = 0; i < N; i++)
        for (int j = 0; j < int'(tbl[t].cnt[4*i +: 4]); j++)
          push(i, 24'(t * 4096 + i * 256 + j));
      build_model();
      drain(200, 1'b0);
      check_run("tbl");
      chk("tbl_n_out", got_lane.size(), tbl[t].n_out);
      for (int i = 0; i < got_lane.size() && i < 8; i++)
        chk("tbl_order", got_lane[i], tbl[t].order[2*i +: 2]);
      for (int i = 1; i < acc_cyc.size(); i++)
        chk("tbl_throughput", acc_cyc[i] - acc_cyc[i-1], 3);
    end

    // Stall in HOLD, START while busy, pointer wrap after lane 3.
    LANE_DONE = '0;
    start_run(5'h15);
    push(0, 24'hA0A0A0);
    wait_valid();
    chk("stall_lane", OUT_LANE, 0);
    chk("stall_data", OUT_DATA, 24'hA0A0A0);
    d = OUT_DATA;
    l = OUT_LANE;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 4) begin START = 1'b1; BITSTREAM = 5'h0A; end
      if (k == 5) START = 1'b0;
      #1;
      chk("stall_hold", {OUT_VALID, OUT_LANE, OUT_DATA, LANE_RDEN}, {1'b1, l, d, 4'b0000});
    end
    chk("busy_start_ignored", LANE_BITSTREAM, 5'h15);
    chk("busy_still", BUSY, 1);
    accept();
    chk("stall_accept_valid", OUT_VALID, 0);
    chk("stall_accept_cnt", SUBKEY_CNT, 1);
    push(3, 24'hB3B3B3);
    wait_valid();
    chk("ptr1_lane", OUT_LANE, 3);
    chk("ptr1_data", OUT_DATA, 24'hB3B3B3);
    accept();
    push(0, 24'hC0C0C0);
    push(3, 24'hD3D3D3);
    #1;
    chk("wrap_grant", LANE_RDEN, 4'b0001);
    wait_valid();
    chk("wrap_lane", OUT_LANE, 0);
    chk("wrap_data", OUT_DATA, 24'hC0C0C0);
    accept();
    wait_valid();
    chk("wrap_lane_next", OUT_LANE, 3);
    accept();
    LANE_DONE = '1;
    for (int k = 0; k < 10; k++) begin
      if (DONE) break;
      tick(); #1;
    end
    chk("wrap_done", DONE, 1);
    chk("wrap_busy", BUSY, 0);
    chk("wrap_cnt", SUBKEY_CNT, 4);

    // ABORT during READ, coinciding with START.
    LANE_DONE = '0;
    start_run(5'h1C);
    push(2, 24'h2E2E2E);
    #1;
    chk("abort_grant", LANE_RDEN, 4'b0100);
    tick();
    ABORT = 1'b1; START = 1'b1; BITSTREAM = 5'h03;
    tick();
    ABORT = 1'b0; START = 1'b0;
    #1;
    chk("abort_busy", BUSY, 0);
    chk("abort_valid", OUT_VALID, 0);
    chk("abort_done", DONE, 0);
    chk("abort_resetn", LANE_RESETn, 0);
    chk("abort_rden", LANE_RDEN, 0);
    chk("abort_start_dropped", LANE_BITSTREAM, 5'h1C);
    tick(); #1;
    chk("abort_stays_idle", BUSY, 0);
    start_run(5'h07);
    build_model();
    drain(50, 1'b0);
    check_run("post_abort");

    // Randomized runs: random fill, random backpressure, lanes finishing late.
    for (int r = 0; r < 4; r++) begin
      LANE_DONE = '0;
      for (int i = 0; i < N; i++) done_at[i] = $urandom_range(0, 40);
      start_run(5'($urandom));
      for (int i = 0; i < N; i++) begin
        int n;
        n = $urandom_range(0, 6);
        for (int j = 0; j < n; j++) push(i, 24'($urandom));
      end
      build_model();
      drain(3000, 1'b1);
      check_run("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/subkey_arbiter.md
# subkey_arbiter

Sequencer and round-robin arbiter for a bank of N subkey-generator lanes in the Crypto1 key-recovery engine. It latches the 5-bit bitstream window and restarts all lanes on START. It drains every lane's subkey FIFO fairly into a single valid/ready output stream, and reports overall completion once every lane has finished and been emptied.

## Interface
- N, 16: number of generator lanes (2..16); lane index width LW = $clog2(N)
- CNT_W, 32: width of emitted-subkey counter
- CLK  in  1  clock
- RESET  in  1  reset, asynchronous, active-high
- START  in  1  one-cycle pulse; begins a run (ignored unless IDLE)
- ABORT  in  1  level/pulse; terminates run from any state
- BITSTREAM  in  5  bitstream window, sampled on accepted START
- LANE_BITSTREAM  out  5  latched window broadcast to all lanes
- LANE_RESETn  out  1  synchronous active-low restart to all lanes
- LANE_DONE  in  N  per-lane enumeration finished
- LANE_EMPTY  in  N  per-lane FIFO empty
- LANE_RDDATA  in  24*N  per-lane FIFO read data, lane i at [24i+23:24i]
- LANE_RDEN  out  N  per-lane FIFO read strobe, one-hot or zero
- OUT_VALID  out  1  subkey available
- OUT_READY  in  1  downstream accepts
- OUT_DATA  out  24  subkey
- OUT_LANE  out  LW  originating lane
- BUSY  out  1  run in progress (state not IDLE)
- DONE  out  1  last run completed normally; level
- SUBKEY_CNT  out  CNT_W  subkeys accepted downstream this run, saturating

## Operation
- Reset values: state IDLE, OUT_VALID 0, OUT_DATA 0, OUT_LANE 0, LANE_RESETn 0, LANE_RDEN 0, LANE_BITSTREAM 0, BUSY 0, DONE 0, SUBKEY_CNT 0, round-robin pointer 0.
- States: IDLE, CLEAR, SCAN, READ, HOLD.
- IDLE: LANE_RESETn=0 (lanes parked). START: latch BITSTREAM into LANE_BITSTREAM, DONE<=0, SUBKEY_CNT<=0, pointer<=0, clear-counter<=0 -> CLEAR.
- CLEAR: LANE_RESETn=0 for exactly 2 cycles, then -> SCAN with LANE_RESETn=1.
- SCAN: grant first lane with LANE_EMPTY=0 searching from pointer upward with wrap. On grant: LANE_RDEN[g]=1 combinationally this cycle, record g -> READ. If no non-empty lane and &LANE_DONE: DONE<=1 -> IDLE. Else stay.
- READ: capture LANE_RDDATA[g] into OUT_DATA, OUT_LANE<=g, OUT_VALID<=1 -> HOLD. FIFO read data is valid the cycle after rd_en.
- HOLD: OUT_DATA/OUT_LANE stable while OUT_VALID=1. On OUT_VALID&OUT_READY: OUT_VALID<=0, SUBKEY_CNT+=1 (saturate at all-ones), pointer<=g+1 wrapping at N -> SCAN.
- ABORT (any non-IDLE state, highest priority): OUT_VALID<=0, LANE_RDEN=0, DONE unchanged (stays 0) -> IDLE. ABORT in IDLE: no effect. ABORT and START together: ABORT wins, START dropped.
- START while BUSY: ignored, no relatch.
- LANE_RDEN never asserted to an empty lane, never outside SCAN, never during ABORT.
- BUSY = (state != IDLE).

## Timing
- START at cycle t: LANE_RESETn low t+1..t+2, high from t+3; first SCAN at t+3.
- Grant to OUT_VALID: RDEN at cycle s, OUT_VALID high at s+2.
- Handshake back-to-back: OUT_READY high continuously -> one subkey per 3 cycles (SCAN, READ, HOLD).
- Completion: DONE rises the cycle after the SCAN that sees all lanes done and empty; BUSY falls same edge.
- Fairness: a lane with data waits at most N-1 grants.

## Structure
- Package crypto1_pkg: arb_state_t enum (IDLE=0, CLEAR=1, SCAN=2, READ=3, HOLD=4), SUBKEY_W=24, BITSTREAM_W=5.
- Sub-module rr_select: combinational N-wide rotate/find-first from pointer; outputs found flag and index.

## Test plan
- N=4, START with BITSTREAM=5'h15 -> LANE_BITSTREAM=5'h15, LANE_RESETn low exactly 2 cycles, BUSY=1.
- Lanes 0 and 2 each preloaded with 3 subkeys, OUT_READY=1 -> output order lane 0,2,0,2,0,2; SUBKEY_CNT=6; then all LANE_DONE=1 -> DONE=1, BUSY=0.
- OUT_READY low 10 cycles during HOLD -> OUT_DATA/OUT_LANE constant, no further LANE_RDEN, nothing lost.
- Only lane 3 non-empty with pointer at 1 -> grant lane 3, pointer wraps to 0 after accept.
- ABORT in READ -> IDLE next cycle, OUT_VALID=0, DONE=0, LANE_RESETn=0; START accepted afterwards.
- All LANE_DONE=1 but lane 1 non-empty -> DONE withheld until lane 1 drained and its subkey accepted.
